// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame debounce, key-code FIFO
// and a four-register memory-mapped interface for the core.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   col_sel[3:0]     active-low column drive (4'hF when disabled)
//   row_in[3:0]      active-low row sense, already synchronized
//   A[1:0]           register select: 0 STATUS, 1 DATA, 2 CTRL, 3 KEYS
//   WE, write_data   register write strobe and data
//   read_data[31:0]  combinational read of the selected register
//   key_ready        high while the key-code FIFO holds an entry
module keypad_scan #(
    parameter int SCAN_DIV   = 2500,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  col_sel,
    input  logic [3:0]  row_in,
    input  logic [1:0]  A,
    input  logic        WE,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        key_ready
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic          enable;
    logic [DW-1:0] div;
    logic [1:0]    col;
    logic [15:0]   raw;
    logic [15:0]   raw_prev;
    logic [15:0]   frame;
    logic [SW-1:0] stab;
    logic [15:0]   deb;
    logic [15:0]   deb_prev;
    logic [15:0]   newk;
    logic [3:0]    code;
    logic          last;
    logic          frame_end;
    logic          push;
    logic          multi_in;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] count;
    logic          full;
    logic          pop_req;
    logic          ctrl_wr;
    logic          do_pop;
    logic          do_push;
    logic          ovf;
    logic          multi;
    logic [2:0]    cnt3;

    assign last      = (div == DW'(SCAN_DIV - 1));
    assign frame_end = last && (col == 2'd3);
    assign col_sel   = enable ? ~(4'b0001 << col) : 4'hF;

    // Raw frame with the current column's rows merged in; at frame end
    // this is the complete new frame.
    always_comb begin
        frame = raw;
        frame[{col, 2'b00} +: 4] = ~row_in;
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            div      <= '0;
            col      <= 2'd0;
            raw      <= '0;
            raw_prev <= '0;
            stab     <= '0;
        end else begin
            if (last) begin
                div <= '0;
                col <= col + 2'd1;
                raw <= frame;
            end else begin
                div <= div + DW'(1);
            end
            if (frame_end) begin
                raw_prev <= frame;
                if (frame != raw_prev)
                    stab <= '0;
                else if (stab != SW'(DEBOUNCE))
                    stab <= stab + SW'(1);
            end
        end
    end

    // Debounced state moves only on the frame where the count reaches
    // DEBOUNCE; it survives disable.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb      <= '0;
            deb_prev <= '0;
        end else begin
            deb_prev <= deb;
            if (enable && frame_end && frame == raw_prev &&
                stab == SW'(DEBOUNCE - 1))
                deb <= frame;
        end
    end

    assign newk     = deb & ~deb_prev;
    assign push     = |newk;
    assign multi_in = |(newk & (newk - 16'd1));

    // Lowest set index wins.
    always_comb begin
        code = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (newk[i])
                code = 4'(i);
    end

    assign pop_req = WE && (A == 2'd1);
    assign ctrl_wr = WE && (A == 2'd2);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop_req && (count != '0);
    // A pop in the same cycle frees the slot for a push into a full FIFO.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            enable <= 1'b1;
            ovf    <= 1'b0;
            multi  <= 1'b0;
            wp     <= '0;
            rp     <= '0;
            count  <= '0;
        end else begin
            if (ctrl_wr) begin
                enable <= write_data[0];
                if (write_data[1]) begin
                    ovf   <= 1'b0;
                    multi <= 1'b0;
                end
            end
            if (push && full && !do_pop)
                ovf <= 1'b1;
            if (push && multi_in)
                multi <= 1'b1;
            if (do_push)
                wp <= wp + PW'(1);
            if (do_pop)
                rp <= rp + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp] <= code;
    end

    assign key_ready = (count != '0);
    assign cnt3      = 3'(count);

    always_comb begin
        read_data = 32'd0;
        unique case (A)
            2'd0: read_data = {25'd0, cnt3, multi, ovf, full, key_ready};
            2'd1: read_data = key_ready ? {28'd0, mem[rp]} : 32'd0;
            2'd2: read_data = {31'd0, enable};
            2'd3: read_data = {16'd0, deb};
        endcase
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Memory-mapped 4x4 matrix keypad scanner. It is the input-side counterpart of the multiplexed seven-segment display driver. The display driver steps a select line and drives segment data out; this block steps an active-low column select and senses the row lines. It debounces full scan frames, encodes each new key press as a 4-bit code into a small FIFO, and exposes status, data and control registers to the MIPS core through the SoC address decoder. `key_ready` is a level suitable for the core's interrupt input, alongside `faccel_done` and `FPM_done`.

## Interface
- `SCAN_DIV`, 2500: clocks each column is driven (dwell); must be ≥ 2.
- `DEBOUNCE`, 4: consecutive identical frames required before the debounced state updates; must be ≥ 1.
- `FIFO_DEPTH`, 4: key-code FIFO entries; power of 2.
- `clk` in 1: system clock (the core's `clk_db` domain).
- `reset` in 1: synchronous, active-high.
- `col_sel` out 4: active-low column drive; exactly one bit low when enabled, 4'hF when disabled.
- `row_in` in 4: active-low row sense; pulled up off-chip and already synchronized.
- `A` in 2: register select (`dataadr[3:2]`).
- `WE` in 1: register write strobe.
- `write_data` in 32: write data.
- `read_data` out 32: combinational read of the register selected by `A`.
- `key_ready` out 1: high while the FIFO is non-empty.

## Operation
- Register map:
  - A=0 STATUS (read-only): [0] not-empty, [1] full, [2] overflow (sticky), [3] multi (sticky), [6:4] count, all other bits 0.
  - A=1 DATA: read returns {28'b0, head code}, or 0 when empty. A write with any data pops the FIFO.
  - A=2 CTRL: [0] enable, reset value 1. Writing [1]=1 clears overflow and multi; that bit is not stored. Reads return {31'b0, enable}.
  - A=3 KEYS (read-only): {16'b0, debounced key bitmap}.
- Scan:
  - A divider counts 0..SCAN_DIV-1 per column. The column index (0..3) advances and wraps at divider terminal count.
  - `col_sel` = ~(1 << col) while enabled.
  - On the last dwell cycle of each column, `~row_in` is sampled into raw frame bits [col*4+3 : col*4]. Key code = col*4 + row.
- Debounce, on the last dwell cycle of column 3 (frame end):
  - If the new raw frame differs from the previous raw frame, stab_cnt ← 0.
  - Otherwise stab_cnt increments, saturating at DEBOUNCE.
  - On the edge where stab_cnt becomes DEBOUNCE, debounced ← raw.
- Press detect:
  - new = debounced & ~debounced_prev.
  - If new ≠ 0, push the lowest set index, one cycle after the debounced update.
  - If more than one bit of new is set, also set multi.
  - Releases push nothing.
- FIFO behaviour:
  - Push when full: entry dropped, overflow set.
  - Pop when empty: ignored.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: push only.
  - Pointers wrap modulo FIFO_DEPTH.
- Disable (CTRL[0]=0):
  - `col_sel`=4'hF; divider, column, raw frame and stab_cnt held at 0.
  - debounced, FIFO and flags are retained.
  - Re-enable restarts at column 0, divider 0.

## Timing
- Reset values: `col_sel`=4'b1110, `key_ready`=0. Divider, column, stab_cnt, raw and debounced = 0. FIFO empty; overflow and multi 0; enable 1.
- `read_data` at reset is 0 for A=0, A=1 and A=3, and 1 for A=2.
- Frame length is 4·SCAN_DIV clocks.
- A key stable from frame k (the first differing frame) updates debounced at the end of frame k+DEBOUNCE.
- FIFO push occurs one clock later; `key_ready` and STATUS reflect it on the following clock.
- Register writes take effect on the `WE` edge. A pop is visible in `read_data` the next cycle.
- Reset mid-scan or with a non-empty FIFO returns every register to its reset value on the next edge; no stale entries survive.

## Test plan
- **Reset check.** Hold `reset` 2 cycles, then release → `col_sel`=4'b1110, `key_ready`=0, STATUS=0, CTRL reads 1.
- **Single press** (SCAN_DIV=4, DEBOUNCE=2). Drive row 2 low only while column 1 is selected (key 6) from frame 0 → KEYS=16'h0040 after end of frame 2. DATA=6 and `key_ready`=1 two clocks later. Write A=1 → `key_ready`=0, DATA=0.
- **Bounce rejection.** Toggle key 6 every frame for 5 frames, then release → no push, KEYS=0, STATUS=0.
- **Simultaneous press.** Assert keys 3 and 9 in the same frame → one push of code 3; STATUS[3]=1, count=1. Write CTRL=32'h3 → multi cleared, enable still 1.
- **Overflow.** Five press/release cycles of key 0 without popping → count=4, full=1, overflow=1, DATA=0. Pop and push in the same cycle → count stays 4, overflow unchanged.
- **Disable mid-frame.** Write CTRL=0 while column 2 is selected → `col_sel`=4'hF next cycle, FIFO contents retained. Write CTRL=1 → `col_sel`=4'b1110 and scanning resumes.
